elevator_ctrl_n: RTL and testbench
==================================

Name: elevator_ctrl_n

Overview:
Parametrised N-floor elevator controller. It is the successor to the 4-floor direction-state controller. It latches floor requests into a pending mask and serves them in SCAN order, continuing in the current direction while requests remain ahead. Travel time per floor and door dwell time are modelled with counters. It sits between the hall/car request inputs and the floor display, motor and door drivers.

Parameters:
NUM_FLOORS, 8, number of floors (2..16); floors are numbered 0..NUM_FLOORS-1.
FLOOR_W, 3, width of the floor index; must be at least clog2(NUM_FLOORS).
TRAVEL_CYCLES, 4, clock cycles to move one floor (at least 1).
DOOR_CYCLES, 6, clock cycles the door stays open (at least 1).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
req  in  NUM_FLOORS  request bit per floor; a one-cycle pulse or a held level are both accepted.
floor  out  FLOOR_W  current floor (registered).
dir  out  1  travel direction: 0 = UP, 1 = DOWN (registered).
moving  out  1  high while in the MOVE state.
door_open  out  1  high while in the DOOR state.
arrive  out  1  one-cycle pulse on the cycle floor takes a new value.
pending  out  NUM_FLOORS  latched, unserved requests.

Behaviour:
- Reset (async) forces: state IDLE, floor 0, dir UP, pending 0, moving 0, door_open 0, arrive 0, both counters 0.
- Request latching:
  - Every edge: pending <= pending | req, except the bit being served in the same cycle.
  - While in DOOR, req[floor] is not latched; it restarts the door counter instead.
- "ahead" means any pending bit above floor when dir=UP, or below floor when dir=DOWN. "behind" is the opposite side.
- IDLE decision, using registered pending; priority order:
  - pending[floor] set: go to DOOR and clear that bit.
  - ahead set: go to MOVE, dir unchanged.
  - behind set: toggle dir, go to MOVE.
  - otherwise stay in IDLE.
  - A request latched at edge t is acted on at edge t+1.
- MOVE:
  - The travel counter counts 0..TRAVEL_CYCLES-1.
  - At terminal count, floor <= floor±1 per dir, arrive=1 on the following cycle, and the counter is cleared.
  - Same edge, decision on (pending|req) at the new floor:
    - bit for the new floor set: go to DOOR, clear that bit.
    - else ahead still set: stay in MOVE.
    - else: go to IDLE.
- Boundaries:
  - dir is forced to DOWN on reaching NUM_FLOORS-1 and to UP on reaching 0.
  - floor never leaves 0..NUM_FLOORS-1.
- DOOR:
  - door_open=1 for exactly DOOR_CYCLES cycles, then IDLE.
  - A re-request of the current floor restarts the full DOOR_CYCLES.
  - moving=0 throughout DOOR.
- Simultaneous events: a request for the floor being passed arrives on the same cycle as terminal count. It is served, because the decision uses pending|req.
- Reset mid-MOVE or mid-DOOR returns to floor 0 immediately (model abstraction). All pending requests are lost.
- Request bits for floors at or above NUM_FLOORS do not exist. Floors above NUM_FLOORS-1 are unreachable.
- moving, door_open and arrive are never high in IDLE.

Test Plan:
1. Reset: assert rst mid-run -> same cycle floor=0, dir=0, pending=0, moving=0, door_open=0.
2. Single request: from floor 0 idle, pulse req[3] at cycle 0 -> pending[3]=1 at edge 1; moving=1 from edge 2; floor=1,2,3 at edges 6,10,14 with arrive pulses; door_open cycles 14-19; IDLE at edge 20; pending=0.
3. Same-floor request: at floor 2 idle, pulse req[2] -> DOOR after 2 edges, no movement, door_open for 6 cycles.
4. SCAN preference: at floor 4, dir=UP, pending {1,6} -> serve 6 first, then dir flips to DOWN and serves 1; no stop at floor 4.
5. En-route pickup:
   - Moving 0->5; pulse req[2] while floor=1 -> stops at 2 (door_open), then resumes to 5.
   - A req[1] raised after passing floor 1 is served only after the reversal.
6. Door extend and boundary: hold req[floor] during DOOR for 3 cycles -> door_open lasts 3+6 cycles. Reaching floor 7 with pending {0} -> dir=1, travel down.

Source files
------------

// File: rtl/elevator_ctrl_n.sv
// ---------------------------------------------------------------------------
// elevator_ctrl_n
//
// N-floor elevator controller. Floor requests are latched into a pending
// mask and served in SCAN order: the car keeps travelling in its current
// direction while any request remains ahead of it, and reverses only when
// everything left is behind. Travel time per floor and door dwell time are
// modelled with counters.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   req        in   [NUM_FLOORS] request per floor (pulse or held level)
//   floor      out  [FLOOR_W]    current floor (registered)
//   dir        out  travel direction, 0 = UP, 1 = DOWN (registered)
//   moving     out  high while travelling between floors
//   door_open  out  high while the door is open
//   arrive     out  one-cycle pulse in the cycle floor takes a new value
//   pending    out  [NUM_FLOORS] latched, unserved requests
// ---------------------------------------------------------------------------
module elevator_ctrl_n #(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [TCW-1:0]     T_LAST    = TCW'(TRAVEL_CYCLES - 1);
  localparam logic [DCW-1:0]     D_LAST    = DCW'(DOOR_CYCLES - 1);

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [FLOOR_W-1:0]      floor_n;
  logic                    dir_n;
  logic [NUM_FLOORS-1:0]   pending_n;
  logic                    arrive_n;
  logic [TCW-1:0]          tcnt, tcnt_n;
  logic [DCW-1:0]          dcnt, dcnt_n;

  logic [FLOOR_W-1:0]      step_floor;
  logic                    step_dir;
  logic [NUM_FLOORS-1:0]   cur_bit;
  logic [NUM_FLOORS-1:0]   step_bit;
  logic [NUM_FLOORS-1:0]   req_eff;
  logic [NUM_FLOORS-1:0]   pend_all;

  // One-hot mask of a floor index; indices past the top floor give zero.
  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    onehot = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i == int'(f)) onehot[i] = 1'b1;
    end
  endfunction

  // Any request strictly beyond floor f in direction d.
  function automatic logic any_ahead(input logic [NUM_FLOORS-1:0] m,
                                     input logic [FLOOR_W-1:0]    f,
                                     input logic                  d);
    any_ahead = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (m[i] && (((d == DIR_UP) && (i > int'(f))) ||
                   ((d == DIR_DOWN) && (i < int'(f)))))
        any_ahead = 1'b1;
    end
  endfunction

  // Floor the car reaches at the end of the current hop, clamped to the shaft,
  // and the direction it must take there (forced at the end floors).
  always_comb begin
    if (dir == DIR_DOWN)
      step_floor = (floor == '0) ? floor : floor - FLOOR_W'(1);
    else
      step_floor = (floor == TOP_FLOOR) ? floor : floor + FLOOR_W'(1);

    if (step_floor == TOP_FLOOR)
      step_dir = DIR_DOWN;
    else if (step_floor == '0)
      step_dir = DIR_UP;
    else
      step_dir = dir;
  end

  always_comb begin
    state_n   = state;
    floor_n   = floor;
    dir_n     = dir;
    tcnt_n    = tcnt;
    dcnt_n    = dcnt;
    arrive_n  = 1'b0;

    cur_bit   = onehot(floor);
    step_bit  = onehot(step_floor);

    // With the door open, a call for this floor holds the door instead of
    // becoming a pending request.
    req_eff   = (state == S_DOOR) ? (req & ~cur_bit) : req;
    pend_all  = pending | req_eff;
    pending_n = pend_all;

    case (state)
      S_IDLE: begin
        // Decision uses only the registered mask, so a fresh request is
        // acted on one edge after it is latched.
        if ((pending & cur_bit) != '0) begin
          state_n   = S_DOOR;
          pending_n = pend_all & ~cur_bit;
          dcnt_n    = '0;
        end else if (any_ahead(pending, floor, dir)) begin
          state_n = S_MOVE;
          tcnt_n  = '0;
        end else if (any_ahead(pending, floor, ~dir)) begin
          state_n = S_MOVE;
          dir_n   = ~dir;
          tcnt_n  = '0;
        end
      end

      S_MOVE: begin
        if (tcnt == T_LAST) begin
          tcnt_n   = '0;
          floor_n  = step_floor;
          dir_n    = step_dir;
          arrive_n = 1'b1;
          // Raw req is included so a call for the floor being reached on
          // this very edge still stops the car.
          if ((pend_all & step_bit) != '0) begin
            state_n   = S_DOOR;
            pending_n = pend_all & ~step_bit;
            dcnt_n    = '0;
          end else if (any_ahead(pend_all, step_floor, step_dir)) begin
            state_n = S_MOVE;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          tcnt_n = tcnt + TCW'(1);
        end
      end

      S_DOOR: begin
        if ((req & cur_bit) != '0) begin
          dcnt_n = '0;
        end else if (dcnt == D_LAST) begin
          state_n = S_IDLE;
          dcnt_n  = '0;
        end else begin
          dcnt_n = dcnt + DCW'(1);
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      floor   <= '0;
      dir     <= DIR_UP;
      pending <= '0;
      arrive  <= 1'b0;
      tcnt    <= '0;
      dcnt    <= '0;
    end else begin
      state   <= state_n;
      floor   <= floor_n;
      dir     <= dir_n;
      pending <= pending_n;
      arrive  <= arrive_n;
      tcnt    <= tcnt_n;
      dcnt    <= dcnt_n;
    end
  end

  assign moving    = (state == S_MOVE);
  assign door_open = (state == S_DOOR);

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// ---------------------------------------------------------------------------
// tb_elevator_ctrl_n
//
// Directed bench for elevator_ctrl_n with default parameters (8 floors,
// 4 cycles per floor, 6 door cycles). Expected arrival floors and door-open
// durations are queued as each scenario is driven; a monitor pops and
// compares them as the controller produces arrive pulses and door periods.
// ---------------------------------------------------------------------------
module tb_elevator_ctrl_n;

  localparam int NF = 8;
  localparam int FW = 3;

  logic          clk;
  logic          rst;
  logic [NF-1:0] req;
  logic [FW-1:0] floor;
  logic          dir;
  logic          moving;
  logic          door_open;
  logic          arrive;
  logic [NF-1:0] pending;

  int n_total;
  int n_pass;
  int arrive_q[$];
  int door_q[$];

  elevator_ctrl_n #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (FW),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .floor    (floor),
    .dir      (dir),
    .moving   (moving),
    .door_open(door_open),
    .arrive   (arrive),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_floor(input int f);
    int n;
    n = 0;
    while (int'(floor) != f && n < 300) begin
      tick();
      n++;
    end
    chk("wait_floor", 32'(floor), 32'(f));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((moving || door_open || pending != '0) && n < 500) begin
      tick();
      n++;
    end
    chk("wait_idle", {29'd0, moving, door_open, |pending}, 32'd0);
  endtask

  task automatic push_arrivals(input int from, input int to);
    if (to >= from) for (int f = from; f <= to; f++) arrive_q.push_back(f);
    else            for (int f = from; f >= to; f--) arrive_q.push_back(f);
  endtask

  // Scoreboard monitor: samples on the falling edge, away from updates.
  initial begin : monitor
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (arrive === 1'b1) begin
          if (arrive_q.size() == 0) chk("arrive_unexpected", 32'(floor), 32'hFFFF_FFFF);
          else                      chk("arrive_floor", 32'(floor), arrive_q.pop_front());
        end
        if (door_open === 1'b1) begin
          run++;
        end else if (run != 0) begin
          if (door_q.size() == 0) chk("door_unexpected", run, 32'hFFFF_FFFF);
          else                    chk("door_len", run, door_q.pop_front());
          run = 0;
        end
      end else begin
        run = 0;
      end
    end
  end

  initial begin : stim
    n_total = 0;
    n_pass  = 0;
    req     = '0;
    rst     = 1'b0;
    #1 rst  = 1'b1;
    #1;
    chk("rst_floor",   32'(floor),     32'd0);
    chk("rst_dir",     32'(dir),       32'd0);
    chk("rst_pending", 32'(pending),   32'd0);
    chk("rst_moving",  32'(moving),    32'd0);
    chk("rst_door",    32'(door_open), 32'd0);
    chk("rst_arrive",  32'(arrive),    32'd0);
    tick(2);
    rst = 1'b0;
    tick();

    // Single request 0 -> 3 with exact cycle timing.
    push_arrivals(1, 3);
    door_q.push_back(6);
    req = 8'h08;
    tick();                                   // edge 1
    req = '0;
    chk("t2_pending_e1", 32'(pending), 32'h08);
    chk("t2_moving_e1",  32'(moving),  32'd0);
    tick();                                   // edge 2
    chk("t2_moving_e2",  32'(moving),  32'd1);
    tick(3);                                  // edge 5
    chk("t2_floor_e5",   32'(floor),   32'd0);
    tick();                                   // edge 6
    chk("t2_floor_e6",   32'(floor),   32'd1);
    tick(8);                                  // edge 14
    chk("t2_floor_e14",  32'(floor),   32'd3);
    chk("t2_door_e14",   32'(door_open), 32'd1);
    chk("t2_moving_e14", 32'(moving),  32'd0);
    tick(5);                                  // edge 19
    chk("t2_door_e19",   32'(door_open), 32'd1);
    tick();                                   // edge 20
    chk("t2_door_e20",   32'(door_open), 32'd0);
    chk("t2_moving_e20", 32'(moving),  32'd0);
    chk("t2_pending_e20", 32'(pending), 32'd0);

    // Go down to floor 2, then request floor 2 while idle there.
    arrive_q.push_back(2);
    door_q.push_back(6);
    req = 8'h04;
    tick();
    req = '0;
    wait_idle();
    chk("t3_at2", 32'(floor), 32'd2);
    door_q.push_back(6);
    req = 8'h04;
    tick();
    req = '0;
    chk("t3_door_e1",    32'(door_open), 32'd0);
    chk("t3_pending_e1", 32'(pending),   32'h04);
    tick();
    chk("t3_door_e2",    32'(door_open), 32'd1);
    chk("t3_moving_e2",  32'(moving),    32'd0);
    tick(5);
    chk("t3_door_e7",    32'(door_open), 32'd1);
    tick();
    chk("t3_door_e8",    32'(door_open), 32'd0);
    chk("t3_floor_e8",   32'(floor),     32'd2);

    // SCAN: from floor 4 heading up with {1,6} pending, 6 first, then 1.
    push_arrivals(3, 4);
    door_q.push_back(6);
    req = 8'h10;
    tick();
    req = '0;
    wait_idle();
    chk("t4_at4_floor", 32'(floor), 32'd4);
    chk("t4_at4_dir",   32'(dir),   32'd0);
    push_arrivals(5, 6);
    door_q.push_back(6);
    push_arrivals(5, 1);
    door_q.push_back(6);
    req = 8'h42;
    tick();
    req = '0;
    tick();
    chk("t4_start_moving", 32'(moving), 32'd1);
    chk("t4_start_dir",    32'(dir),    32'd0);
    wait_idle();
    chk("t4_end_floor", 32'(floor), 32'd1);
    chk("t4_end_dir",   32'(dir),   32'd1);

    // Return to 0, then 0 -> 5 with a pickup at 2 and a call for 1 behind.
    arrive_q.push_back(0);
    door_q.push_back(6);
    req = 8'h01;
    tick();
    req = '0;
    wait_idle();
    chk("t5_at0_dir", 32'(dir), 32'd0);
    push_arrivals(1, 2);
    door_q.push_back(6);
    push_arrivals(3, 5);
    door_q.push_back(6);
    push_arrivals(4, 1);
    door_q.push_back(6);
    req = 8'h20;
    tick();
    req = '0;
    wait_floor(1);
    req = 8'h04;
    tick();
    req = '0;
    wait_floor(2);
    chk("t5_stop2_door", 32'(door_open), 32'd1);
    req = 8'h02;
    tick();
    req = '0;
    chk("t5_pending_1_5", 32'(pending), 32'h22);
    wait_idle();
    chk("t5_end_floor", 32'(floor), 32'd1);
    chk("t5_end_dir",   32'(dir),   32'd1);

    // Top boundary and door extension: 1 -> 7 with {0} raised en route.
    push_arrivals(2, 7);
    door_q.push_back(9);
    push_arrivals(6, 0);
    door_q.push_back(6);
    req = 8'h80;
    tick();
    req = 8'h01;
    tick();
    req = '0;
    wait_floor(7);
    chk("t6_top_door", 32'(door_open), 32'd1);
    chk("t6_top_dir",  32'(dir),       32'd1);
    req = 8'h80;
    tick(3);
    req = '0;
    chk("t6_hold_not_latched", 32'(pending), 32'h01);
    wait_floor(6);
    chk("t6_down_dir",    32'(dir),    32'd1);
    chk("t6_down_moving", 32'(moving), 32'd1);
    wait_idle();
    chk("t6_end_floor", 32'(floor), 32'd0);
    chk("t6_end_dir",   32'(dir),   32'd0);

    // Reset mid-move: floor returns to 0 at once and requests are dropped.
    push_arrivals(1, 2);
    req = 8'h10;
    tick();
    req = '0;
    wait_floor(2);
    tick();
    chk("t1_pre_moving", 32'(moving), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_floor",   32'(floor),     32'd0);
    chk("t1_rst_dir",     32'(dir),       32'd0);
    chk("t1_rst_pending", 32'(pending),   32'd0);
    chk("t1_rst_moving",  32'(moving),    32'd0);
    chk("t1_rst_door",    32'(door_open), 32'd0);
    tick();
    rst = 1'b0;
    tick(3);
    chk("t1_post_floor",   32'(floor),   32'd0);
    chk("t1_post_moving",  32'(moving),  32'd0);
    chk("t1_post_pending", 32'(pending), 32'd0);

    tick(2);
    chk("arrive_q_drained", 32'(arrive_q.size()), 32'd0);
    chk("door_q_drained",   32'(door_q.size()),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
